// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master_pkg: shared types and constants for the APB command master and its wait timer.
//   state_t          - transfer FSM encoding (IDLE, SETUP, ACCESS, RESP)
//   TO_WIDTH         - width of the saturating wait-state counter
//   DEFAULT_TIMEOUT  - default number of PREADY-low ACCESS cycles before abort
//   sat_inc()        - saturating increment used by the wait timer
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int TO_WIDTH        = 8;
    localparam int DEFAULT_TIMEOUT = 16;

    function automatic logic [TO_WIDTH-1:0] sat_inc(input logic [TO_WIDTH-1:0] v);
        return (v == {TO_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apb_cmd_master_wait_timer.sv
// apb_wait_timer: saturating wait-state counter with an expiry flag, reusable by APB bridges.
//   RegClk, RegReset - clock and asynchronous active-high reset
//   clear            - force the count to 0 (wins over enable)
//   enable           - count one more wait cycle
//   expired          - high in the enabled cycle in which the count reaches TIMEOUT_CYCLES
module apb_wait_timer
    import apb_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic RegClk,
    input  logic RegReset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_WIDTH-1:0] count;
    logic [TO_WIDTH-1:0] count_nxt;
    logic [TO_WIDTH-1:0] limit;

    assign limit = TIMEOUT_CYCLES[TO_WIDTH-1:0];

    always_comb begin
        count_nxt = clear ? '0 : (enable ? sat_inc(count) : count);
    end

    // Flag the cycle whose wait brings the count up to the limit, so the
    // owner can abort on exactly the TIMEOUT_CYCLES-th wait cycle.
    assign expired = enable && !clear && (count_nxt == limit);

    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 requester with a PREADY wait-state timeout.
//   RegClk, RegReset             - clock and asynchronous active-high reset
//   cmd_valid/cmd_ready          - command handshake; cmd_write, cmd_addr, cmd_wdata carry the command
//   rsp_valid/rsp_ready          - response handshake; rsp_rdata, rsp_err, rsp_timeout carry the result
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY, PRDATA, PSLVERR - APB3 requester interface
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                  RegClk,
    input  logic                  RegReset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR
);

    state_t state, state_nxt;
    logic   timer_clear;
    logic   timer_en;
    logic   timer_expired;
    logic   accept;
    logic   finish;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .RegClk  (RegClk),
        .RegReset(RegReset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // cmd_ready is masked by reset so every output reads 0 while reset is held.
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        accept      = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !RegReset;
                accept    = cmd_valid;
                state_nxt = cmd_valid ? SETUP : IDLE;
            end
            SETUP: begin
                PSEL        = 1'b1;
                timer_clear = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                PSEL      = 1'b1;
                PENABLE   = 1'b1;
                timer_en  = !PREADY;
                finish    = PREADY || timer_expired;
                state_nxt = finish ? RESP : ACCESS;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = rsp_ready ? IDLE : RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PREADY wins over a same-cycle expiry; only completed reads return PRDATA.
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (finish) begin
                rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : 32'h0;
                rsp_err     <= PREADY ? PSLVERR : 1'b1;
                rsp_timeout <= !PREADY;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed table plus randomized commands against an APB slave and transaction-level model.
module tb_apb_cmd_master;

    localparam int TO = 16;

    logic        RegClk = 1'b0;
    logic        RegReset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = 8'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int vec = 0;
    int mis = 0;

    always #5 RegClk = ~RegClk;

    apb_cmd_master #(
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .RegClk     (RegClk),
        .RegReset   (RegReset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    // APB slave: eight word registers, index 7 (0x1C) unmapped and answered with PSLVERR.
    logic [31:0] smem [8];
    int wait_n = 0;
    int acc_run = 0;
    int acc_total = 0;
    int rd_pulses = 0;

    assign PREADY  = PSEL && PENABLE && (acc_run >= wait_n);
    assign PSLVERR = PREADY && (PADDR[4:2] == 3'd7);
    assign PRDATA  = (PREADY && PADDR[4:2] != 3'd7) ? smem[PADDR[4:2]] : 32'h0;

    always @(posedge RegClk) begin
        acc_run <= (PSEL && PENABLE && !PREADY) ? acc_run + 1 : 0;
        if (PSEL && PENABLE)
            acc_total <= acc_total + 1;
        if (PSEL && PENABLE && PREADY && !PWRITE)
            rd_pulses <= rd_pulses + 1;
        if (PSEL && PENABLE && PREADY && PWRITE && PADDR[4:2] != 3'd7)
            smem[PADDR[4:2]] <= PWDATA;
    end

    // Reference model state: register contents as seen through completed writes.
    logic [31:0] ref_mem [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input bit w, input logic [7:0] a, input logic [31:0] d, input int wn, input int hold,
                           input logic [31:0] er, input bit ee, input bit et);
        int acc0, rd0, n, exp_acc;
        bit got;
        @(negedge RegClk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        wait_n    = wn;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        acc0      = acc_total;
        rd0       = rd_pulses;
        @(posedge RegClk);
        #1;
        cmd_valid = 1'b0;
        check("setup_phase", 64'({PSEL, PENABLE, PWRITE, PADDR}), 64'({1'b1, 1'b0, w, a}));
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge RegClk);
            #1;
            n++;
            got = rsp_valid;
            if (!got)
                check("access_hold", 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}), 64'({1'b1, 1'b1, w, a, d}));
        end
        if (!got) begin
            mis++;
            $display("FAIL rsp_wait: rsp_valid never rose within 40 cycles");
            return;
        end
        exp_acc = (wn >= TO) ? TO : wn + 1;
        check("latency", 64'(n), 64'(exp_acc + 1));
        check("access_cycles", 64'(acc_total - acc0), 64'(exp_acc));
        check("read_pulses", 64'(rd_pulses - rd0), 64'((!w && wn < TO) ? 1 : 0));
        check("rsp", 64'({PSEL, PENABLE, rsp_rdata, rsp_err, rsp_timeout}), 64'({2'b00, er, ee, et}));
        for (int i = 0; i < hold; i++) begin
            @(negedge RegClk);
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 8'h10;
            @(posedge RegClk);
            #1;
            check("rsp_hold", 64'({rsp_valid, cmd_ready, PSEL, rsp_rdata, rsp_err, rsp_timeout}),
                  64'({3'b100, er, ee, et}));
        end
        @(negedge RegClk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge RegClk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_done", 64'({rsp_valid, cmd_ready, PSEL}), 64'({3'b010}));
        if (w && wn < TO && a[4:2] != 3'd7)
            ref_mem[a[4:2]] = d;
    endtask

    typedef struct {
        bit          w;
        logic [7:0]  a;
        logic [31:0] d;
        int          wn;
        int          hold;
        logic [31:0] er;
        bit          ee;
        bit          et;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          w;
        logic [7:0]  a;
        logic [31:0] d;
        int          wn, hold;
        bit          et, ee;
        logic [31:0] er;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 32'h0;
        end
        tbl[0]  = '{1'b1, 8'h0C, 32'h0000_005A, 0,  0, 32'h0,         1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h00, 32'h0000_0019, 2,  0, 32'h0,         1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h04, 32'h0000_20AB, 0,  0, 32'h0,         1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h04, 32'h0,         0,  0, 32'h0000_20AB, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h0C, 32'h0,         0,  0, 32'h0000_005A, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h1C, 32'h0,         1,  0, 32'h0,         1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h04, 32'h0,         16, 0, 32'h0,         1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'h04, 32'h0,         15, 0, 32'h0000_20AB, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 32'h0,         0,  5, 32'h0000_0019, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h1C, 32'h0000_DEAD, 0,  0, 32'h0,         1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h08, 32'h0,         40, 1, 32'h0,         1'b1, 1'b1};

        #12;
        check("reset_outputs", 64'({cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata, rsp_err, rsp_timeout}),
              64'd0);
        @(negedge RegClk);
        RegReset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_cmd(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].wn, tbl[i].hold, tbl[i].er, tbl[i].ee, tbl[i].et);

        for (int i = 0; i < 40; i++) begin
            w    = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(0, 7) * 4);
            d    = $urandom;
            wn   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 2));
            et   = (wn >= TO);
            ee   = et || (a[4:2] == 3'd7);
            er   = (w || ee) ? 32'h0 : ref_mem[a[4:2]];
            run_cmd(w, a, d, wn, hold, er, ee, et);
        end

        // Asynchronous reset in the middle of a stalled ACCESS phase.
        @(negedge RegClk);
        wait_n    = 10;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0C;
        @(posedge RegClk);
        #1;
        cmd_valid = 1'b0;
        @(posedge RegClk);
        #1;
        check("pre_reset_access", 64'({PSEL, PENABLE}), 64'({2'b11}));
        #2;
        RegReset = 1'b1;
        #1;
        check("async_reset_drop", 64'({PSEL, PENABLE, rsp_valid, cmd_ready, rsp_err, rsp_timeout}), 64'd0);
        @(negedge RegClk);
        RegReset = 1'b0;
        #1;
        check("post_reset_ready", 64'({cmd_ready, PSEL, rsp_valid}), 64'({3'b100}));
        run_cmd(1'b1, 8'h08, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 8'h08, 32'h0, 1, 0, 32'h1234_5678, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
